// File: rtl/id_ex_skid_reg.sv
// Decode->execute pipeline register with valid/ready handshake and a 2-entry skid.
// Optional stall-cycle counter built only when IDEX_STALL_CNT_EN is defined.
//
// state | meaning
// EMPTY | main_valid=0, skid_valid=0; nothing held
// ONE   | main_valid=1, skid_valid=0; entry on outputs, room for one more
// FULL  | main_valid=1, skid_valid=1; in_ready low until execute consumes
module id_ex_skid_reg #(
  parameter int DATA_W = 16,
  parameter int DST_W  = 4,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DST_W-1:0]  dstReg_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DST_W-1:0]  dstReg_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [15:0]       stall_cnt
);

  localparam int ENT_W = 3*DATA_W + DST_W + CTRL_W;

  logic              main_valid;
  logic              skid_valid;
  logic              in_ready_q;
  logic [ENT_W-1:0]  main_q;
  logic [ENT_W-1:0]  skid_q;
  logic [ENT_W-1:0]  in_ent;
  logic              in_fire;
  logic              out_fire;

  assign in_ent   = {rd1_in, rd2_in, imm_in, dstReg_in, ctrl_in};
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_valid & out_ready;

  // in_ready_q always equals ~skid_valid; kept as its own flop so decode sees a clean register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case ({main_valid, skid_valid})
        2'b00: begin
          if (in_fire) begin
            main_q     <= in_ent;
            main_valid <= 1'b1;
          end
        end
        2'b10: begin
          if (in_fire && out_fire) begin
            main_q <= in_ent;
          end else if (in_fire) begin
            skid_q     <= in_ent;
            skid_valid <= 1'b1;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            main_valid <= 1'b0;
          end
        end
        2'b11: begin
          if (out_fire) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign rd1_out   = main_q[ENT_W-1 -: DATA_W];
  assign rd2_out   = main_q[ENT_W-DATA_W-1 -: DATA_W];
  assign imm_out   = main_q[DST_W+CTRL_W +: DATA_W];

  // Bubbles must never look like a write-back or a hazard match
  assign dstReg_out = main_valid ? main_q[CTRL_W +: DST_W] : '0;
  assign ctrl_out   = main_valid ? main_q[CTRL_W-1:0]      : '0;

`ifdef IDEX_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
- Parametrised decode→execute pipeline register; successor to the fixed 16-bit always-enabled stage register.
- Adds valid/ready handshake, a 2-entry skid (main + skid slot), synchronous flush and bubble gating.
- Sits between register-file read / sign-extend in decode and the ALU / forwarding unit in execute.
- Lets execute back-pressure decode without the combinational ready path crossing the stage.

Parameters:
- DATA_W, 16, width of each register-read operand and of the immediate.
- DST_W, 4, destination register index width.
- CTRL_W, 8, width of the opaque control bundle (ALU op, mem/wb enables).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous squash of all held entries (branch mispredict).
- in_valid  input  1  decode presents a valid instruction.
- in_ready  output  1  stage can accept; registered (no combinational path from out_ready).
- rd1_in  input  DATA_W  register-file read data 1.
- rd2_in  input  DATA_W  register-file read data 2.
- imm_in  input  DATA_W  sign-extended immediate.
- dstReg_in  input  DST_W  destination register.
- ctrl_in  input  CTRL_W  control bundle.
- out_valid  output  1  execute-side entry valid.
- out_ready  input  1  execute can consume.
- rd1_out, rd2_out, imm_out  output  DATA_W each  operands for execute.
- dstReg_out  output  DST_W  destination; 0 when out_valid=0.
- ctrl_out  output  CTRL_W  control; 0 when out_valid=0.
- stall_cnt  output  16  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at edge): main_valid=0, skid_valid=0, all data regs=0, in_ready=1, out_valid=0, all outputs 0, stall_cnt=0.
- Reset takes priority over flush and handshakes.
- Transfer rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid = main_valid.
  - in_ready = ~skid_valid, registered.
- State / occupancy:
  - EMPTY: main=0, skid=0.
  - ONE: main=1, skid=0.
  - FULL: main=1, skid=1.
- EMPTY:
  - in_fire → load main, go ONE.
- ONE:
  - in_fire & out_fire → main reloads with the new input, stays ONE.
  - in_fire & ~out_fire → input written to skid, go FULL, in_ready=0 next cycle.
  - ~in_fire & out_fire → go EMPTY.
- FULL:
  - in_ready=0.
  - out_fire → main ← skid, skid cleared, go ONE, in_ready=1 next cycle.
  - No input is accepted in FULL.
- Latency and ordering:
  - Input accepted in cycle N appears on outputs in cycle N+1 when the stage was EMPTY, or after prior entries drain.
  - Strict in-order delivery; no entry dropped or duplicated except on flush.
- Flush:
  - Next state EMPTY; main_valid=0, skid_valid=0, in_ready=1.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed by execute.
  - Data regs hold stale values, but dstReg_out and ctrl_out read 0 because of gating.
- Bubble gating: when out_valid=0, dstReg_out=0 and ctrl_out=0, so a bubble never asserts write-back or hazard matches (R0 is never a hazard).
- Width: all data fields are pure storage, no arithmetic. Total stored bits per entry = 3*DATA_W + DST_W + CTRL_W.

Optional Feature:
- Macro: IDEX_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF; flush does not clear it.
  - Cleared only by reset.
- Undefined: stall_cnt is tied to 16'h0000 and no counter logic is built.

Test Plan:
- Reset/single pass:
  - Stimulus: rst_n=0 for 2 cycles, then in_valid=1, rd1_in=16'h1234, rd2_in=16'hABCD, imm_in=16'hFFF8, dstReg_in=4'd5, out_ready=1.
  - Response: next cycle out_valid=1 with identical fields; during reset all outputs 0 and in_ready=1.
- Back-pressure skid:
  - Stimulus: out_ready=0, send A=16'h0001 then B=16'h0002.
  - Response: in_ready drops to 0 after B is taken; holding out_ready=0 for 5 cycles keeps out=A. Raising out_ready gives A then B on consecutive cycles, and in_ready returns to 1.
- Streaming:
  - Stimulus: 100 back-to-back beats with out_ready=1.
  - Response: one beat out per cycle, in order, in_ready never 0.
- Flush in FULL:
  - Stimulus: FULL with A,B, then flush=1 with in_valid=1 carrying C.
  - Response: next cycle out_valid=0, dstReg_out=0, ctrl_out=0, in_ready=1; C is never output.
- Random handshake:
  - Stimulus: random in_valid/out_ready/flush for 10k cycles.
  - Response: scoreboard matches in-order delivery; flush drops exactly the held entries.
- IDEX_STALL_CNT_EN:
  - Stimulus: hold a valid entry with out_ready=0 for 7 cycles.
  - Response: stall_cnt=7. Force 70000 stall cycles → stall_cnt=16'hFFFF. With the macro undefined, stall_cnt stays 0.
